// File: rtl/sdi_timing_pkg.sv
// sdi_timing_pkg
//   Shared definitions for the SDI transmit timing generator: the black-level
//   pixel used whenever the raster is not fed from the frame buffer, and the
//   source-selection state encoding.
package sdi_timing_pkg;

    localparam logic [9:0]  BLACK_Y     = 10'h040;
    localparam logic [9:0]  BLACK_C     = 10'h200;
    localparam logic [19:0] BLACK_PIXEL = {BLACK_Y, BLACK_C};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LIVE  = 2'd1,
        BLACK = 2'd2
    } state_t;

endpackage

// File: rtl/sdi_hv_counter.sv
// sdi_hv_counter
//   Raster position counter. h_cnt runs 0..H_TOTAL-1, v_cnt advances on each
//   h wrap and runs 0..V_TOTAL-1.
// Ports
//   clk_sdi  in   pixel clock
//   rst      in   asynchronous reset, active-high
//   run      in   advance the raster by one pixel per clock
//   clear    in   force both counters to 0 (has priority over run)
//   h_cnt    out  horizontal position
//   v_cnt    out  vertical position
//   fb       out  last pixel of the frame while running (frame boundary)
module sdi_hv_counter #(
    parameter int unsigned H_TOTAL = 2200,
    parameter int unsigned V_TOTAL = 1125,
    parameter int unsigned CNT_W   = 12
) (
    input  logic             clk_sdi,
    input  logic             rst,
    input  logic             run,
    input  logic             clear,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             fb
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    logic h_last;
    logic v_last;

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);
    assign fb     = run & h_last & v_last;

    always_ff @(posedge clk_sdi or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (clear) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (run) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdi_tx_timing_gen.sv
// sdi_tx_timing_gen
//   Master raster timing generator for the SDI transmit path. Produces
//   blanking/active/sof timing, fetches active pixels from the frame buffer
//   while the input is good, and substitutes a black raster on video loss.
//   Source changes only take effect on frame boundaries.
// Ports
//   clk_sdi         in   pixel clock
//   rst             in   asynchronous reset, active-high
//   enable          in   run request, acted on in IDLE and at frame boundary
//   vid_in_loss_n   in   0 = input video lost
//   vid_rd_req      out  frame-buffer read strobe, one per active LIVE pixel
//   vid_rd_data     in   {Y,C} read data, valid one clock after vid_rd_req
//   vid_out_data    out  {Y,C} output pixel
//   vid_out_hblank  out  horizontal blanking
//   vid_out_vblank  out  vertical blanking
//   vid_out_active  out  active picture while running
//   vid_out_sof     out  one-clock pulse on pixel (0,0)
//   vid_out_h_cnt   out  horizontal position of the output pixel
//   vid_out_v_cnt   out  vertical position of the output pixel
//   src_black       out  output raster is generated black
module sdi_tx_timing_gen
    import sdi_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE       = 1920,
    parameter int unsigned H_TOTAL        = 2200,
    parameter int unsigned V_ACTIVE       = 1080,
    parameter int unsigned V_TOTAL        = 1125,
    parameter int unsigned CNT_W          = 12,
    parameter int unsigned RECOVER_FRAMES = 2
) (
    input  logic             clk_sdi,
    input  logic             rst,
    input  logic             enable,
    input  logic             vid_in_loss_n,
    output logic             vid_rd_req,
    input  logic [19:0]      vid_rd_data,
    output logic [19:0]      vid_out_data,
    output logic             vid_out_hblank,
    output logic             vid_out_vblank,
    output logic             vid_out_active,
    output logic             vid_out_sof,
    output logic [CNT_W-1:0] vid_out_h_cnt,
    output logic [CNT_W-1:0] vid_out_v_cnt,
    output logic             src_black
);

    localparam int unsigned      REC_W       = $clog2(RECOVER_FRAMES + 1);
    localparam logic [REC_W-1:0] REC_LAST    = REC_W'(RECOVER_FRAMES - 1);
    localparam logic [CNT_W-1:0] H_ACT       = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT       = CNT_W'(V_ACTIVE);
    localparam bit               START_BLACK = (RECOVER_FRAMES > 1);

    state_t           state_q, state_d;
    logic [REC_W-1:0] rec_q, rec_d;
    logic             loss_q, loss_d;
    logic             loss_now;

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             fb;
    logic             running;
    logic             hblank0, vblank0, active0, sof0;
    logic             req_q;

    assign running = (state_q != IDLE);

    sdi_hv_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .CNT_W   (CNT_W)
    ) u_hv (
        .clk_sdi (clk_sdi),
        .rst     (rst),
        .run     (running),
        .clear   (~running),
        .h_cnt   (h_cnt),
        .v_cnt   (v_cnt),
        .fb      (fb)
    );

    // Stage 0: raster decode. IDLE presents the reset-value timing.
    assign hblank0    = ~running | (h_cnt >= H_ACT);
    assign vblank0    = ~running | (v_cnt >= V_ACT);
    assign active0    = ~hblank0 & ~vblank0;
    assign sof0       = running & (h_cnt == '0) & (v_cnt == '0);
    assign vid_rd_req = (state_q == LIVE) & active0;

    // A loss seen at any point in the frame counts at the boundary.
    assign loss_now = loss_q | ~vid_in_loss_n;

    always_ff @(posedge clk_sdi or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rec_q   <= '0;
            loss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rec_q   <= rec_d;
            loss_q  <= loss_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rec_d   = rec_q;
        loss_d  = loss_q;
        unique case (state_q)
            IDLE: begin
                loss_d = 1'b0;
                rec_d  = '0;
                if (enable)
                    state_d = (~vid_in_loss_n | START_BLACK) ? BLACK : LIVE;
            end
            LIVE: begin
                if (fb) begin
                    loss_d = 1'b0;
                    rec_d  = '0;
                    if (!enable)
                        state_d = IDLE;
                    else if (loss_now)
                        state_d = BLACK;
                end else begin
                    loss_d = loss_now;
                end
            end
            BLACK: begin
                if (fb) begin
                    loss_d = 1'b0;
                    if (!enable) begin
                        state_d = IDLE;
                        rec_d   = '0;
                    end else if (loss_now) begin
                        rec_d = '0;
                    end else if (rec_q >= REC_LAST) begin
                        state_d = LIVE;
                        rec_d   = '0;
                    end else begin
                        rec_d = rec_q + 1'b1;
                    end
                end else begin
                    loss_d = loss_now;
                end
            end
            default: begin
                state_d = IDLE;
                rec_d   = '0;
                loss_d  = 1'b0;
            end
        endcase
    end

    // Stage 1: timing registered one clock behind the counters.
    always_ff @(posedge clk_sdi or posedge rst) begin
        if (rst) begin
            vid_out_hblank <= 1'b1;
            vid_out_vblank <= 1'b1;
            vid_out_active <= 1'b0;
            vid_out_sof    <= 1'b0;
            vid_out_h_cnt  <= '0;
            vid_out_v_cnt  <= '0;
            src_black      <= 1'b1;
            req_q          <= 1'b0;
        end else begin
            vid_out_hblank <= hblank0;
            vid_out_vblank <= vblank0;
            vid_out_active <= active0;
            vid_out_sof    <= sof0;
            vid_out_h_cnt  <= h_cnt;
            vid_out_v_cnt  <= v_cnt;
            src_black      <= (state_q != LIVE);
            req_q          <= vid_rd_req;
        end
    end

    // Read data arrives in the same cycle the pixel is presented at stage 1,
    // so the select is registered and the data path is a direct mux.
    assign vid_out_data = req_q ? vid_rd_data : BLACK_PIXEL;

endmodule

// File: tb/tb_sdi_tx_timing_gen.sv
module tb_sdi_tx_timing_gen;

    localparam int unsigned H_ACTIVE       = 8;
    localparam int unsigned H_TOTAL        = 12;
    localparam int unsigned V_ACTIVE       = 4;
    localparam int unsigned V_TOTAL        = 6;
    localparam int unsigned CNT_W          = 4;
    localparam int unsigned RECOVER_FRAMES = 2;
    localparam int          FRAME          = H_TOTAL * V_TOTAL;
    localparam logic [19:0] BLACK_PX       = {10'h040, 10'h200};

    logic             clk_sdi = 1'b0;
    logic             rst;
    logic             enable;
    logic             vid_in_loss_n;
    logic             vid_rd_req;
    logic [19:0]      vid_rd_data;
    logic [19:0]      vid_out_data;
    logic             vid_out_hblank;
    logic             vid_out_vblank;
    logic             vid_out_active;
    logic             vid_out_sof;
    logic [CNT_W-1:0] vid_out_h_cnt;
    logic [CNT_W-1:0] vid_out_v_cnt;
    logic             src_black;

    sdi_tx_timing_gen #(
        .H_ACTIVE       (H_ACTIVE),
        .H_TOTAL        (H_TOTAL),
        .V_ACTIVE       (V_ACTIVE),
        .V_TOTAL        (V_TOTAL),
        .CNT_W          (CNT_W),
        .RECOVER_FRAMES (RECOVER_FRAMES)
    ) dut (
        .clk_sdi        (clk_sdi),
        .rst            (rst),
        .enable         (enable),
        .vid_in_loss_n  (vid_in_loss_n),
        .vid_rd_req     (vid_rd_req),
        .vid_rd_data    (vid_rd_data),
        .vid_out_data   (vid_out_data),
        .vid_out_hblank (vid_out_hblank),
        .vid_out_vblank (vid_out_vblank),
        .vid_out_active (vid_out_active),
        .vid_out_sof    (vid_out_sof),
        .vid_out_h_cnt  (vid_out_h_cnt),
        .vid_out_v_cnt  (vid_out_v_cnt),
        .src_black      (src_black)
    );

    always #5 clk_sdi = ~clk_sdi;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: source mode (0 off, 1 frame buffer, 2 black), position
    // inside the frame, good frames seen while black, loss seen this frame.
    int m_mode, m_pos, m_good;
    bit m_lost;
    // Expected output-side view of the previous pixel.
    bit e_hb, e_vb, e_act, e_sof, e_black, e_req;
    int e_h, e_v;

    logic [19:0] next_data;
    int          reqs_seen;
    int          cyc;
    int          sof_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_good = 0; m_lost = 0;
        e_hb = 1; e_vb = 1; e_act = 0; e_sof = 0; e_h = 0; e_v = 0;
        e_black = 1; e_req = 0;
    endtask

    function automatic bit pixel_active(input int mode, input int pos);
        return (mode != 0) && (pos % H_TOTAL < H_ACTIVE) && (pos / H_TOTAL < V_ACTIVE);
    endfunction

    task automatic model_edge(input bit en, input bit lossn);
        bit lost_now;
        e_h     = m_pos % H_TOTAL;
        e_v     = m_pos / H_TOTAL;
        e_hb    = (m_mode == 0) || (e_h >= H_ACTIVE);
        e_vb    = (m_mode == 0) || (e_v >= V_ACTIVE);
        e_act   = pixel_active(m_mode, m_pos);
        e_sof   = (m_mode != 0) && (m_pos == 0);
        e_black = (m_mode != 1);
        e_req   = e_act && (m_mode == 1);
        if (m_mode == 0) begin
            if (en) begin
                m_mode = (!lossn || RECOVER_FRAMES > 1) ? 2 : 1;
                m_pos = 0; m_good = 0; m_lost = 0;
            end
        end else begin
            lost_now = m_lost || !lossn;
            if (m_pos == FRAME - 1) begin
                m_pos = 0; m_lost = 0;
                if (!en) begin
                    m_mode = 0; m_good = 0;
                end else if (m_mode == 1) begin
                    if (lost_now) begin m_mode = 2; m_good = 0; end
                end else if (lost_now) begin
                    m_good = 0;
                end else begin
                    m_good++;
                    if (m_good >= RECOVER_FRAMES) begin m_mode = 1; m_good = 0; end
                end
            end else begin
                m_pos++;
                m_lost = lost_now;
            end
        end
    endtask

    // One clock: apply read data, check all outputs mid-cycle, advance the model.
    task automatic cycle();
        logic [19:0] applied;
        bit          exp_req;
        @(negedge clk_sdi);
        applied     = next_data;
        vid_rd_data = applied;
        #1;
        exp_req = pixel_active(m_mode, m_pos) && (m_mode == 1) && !rst;
        check("rd_req",    vid_rd_req,     exp_req);
        check("hblank",    vid_out_hblank, e_hb);
        check("vblank",    vid_out_vblank, e_vb);
        check("active",    vid_out_active, e_act);
        check("sof",       vid_out_sof,    e_sof);
        check("h_cnt",     vid_out_h_cnt,  e_h);
        check("v_cnt",     vid_out_v_cnt,  e_v);
        check("src_black", src_black,      e_black);
        check("data",      vid_out_data,   e_req ? applied : BLACK_PX);
        if (vid_rd_req) reqs_seen++;
        if (vid_out_sof) sof_q.push_back(cyc);
        cyc++;
        next_data = 20'($urandom);
        if (!rst) model_edge(enable, vid_in_loss_n);
        @(posedge clk_sdi);
        #1;
    endtask

    task automatic run_to(input int target);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (m_pos != target && n < 4 * FRAME);
        if (m_pos != target) check("run_to_timeout", m_pos, target);
    endtask

    initial begin
        rst = 1; enable = 0; vid_in_loss_n = 1; vid_rd_data = '0;
        next_data = '0; reqs_seen = 0; cyc = 0;
        model_reset();
        repeat (3) cycle();
        rst = 0;
        repeat (4) cycle();

        // 1: start-up goes through two black frames, then live.
        enable = 1;
        reqs_seen = 0;
        cycle();
        run_to(0);
        run_to(0);
        check("t1_black_reqs", reqs_seen, 0);
        reqs_seen = 0;
        repeat (FRAME) cycle();
        check("t1_live_reqs", reqs_seen, H_ACTIVE * V_ACTIVE);
        check("t1_sof_period", sof_q[$] - sof_q[$-1], FRAME);

        // 2: one-clock loss at (3,1) while live.
        run_to(1 * H_TOTAL + 3);
        vid_in_loss_n = 0;
        cycle();
        vid_in_loss_n = 1;
        run_to(0);
        reqs_seen = 0;
        run_to(0);
        run_to(0);
        check("t2_black_reqs", reqs_seen, 0);
        reqs_seen = 0;
        run_to(0);
        check("t2_live_reqs", reqs_seen, H_ACTIVE * V_ACTIVE);

        // 3: loss glitch inside the second recovery frame restarts recovery.
        run_to(20);
        vid_in_loss_n = 0; cycle(); vid_in_loss_n = 1;
        run_to(0);
        run_to(0);
        run_to(30);
        vid_in_loss_n = 0; cycle(); vid_in_loss_n = 1;
        run_to(0);
        reqs_seen = 0;
        run_to(0);
        run_to(0);
        check("t3_recover_reqs", reqs_seen, 0);
        reqs_seen = 0;
        run_to(0);
        check("t3_live_reqs", reqs_seen, H_ACTIVE * V_ACTIVE);

        // 4: enable dropped mid-frame; frame completes, then idle.
        run_to(40);
        enable = 0;
        run_to(0);
        reqs_seen = 0;
        repeat (10) cycle();
        check("t4_idle_reqs", reqs_seen, 0);

        // 6: reset pulsed mid-frame, restart in black.
        enable = 1;
        run_to(0);
        run_to(0);
        run_to(2 * H_TOTAL + 5);
        rst = 1;
        model_reset();
        repeat (2) cycle();
        rst = 0;
        cycle();
        run_to(0);

        // Randomized phase: sparse loss glitches and enable toggles.
        for (int i = 0; i < 12 * FRAME; i++) begin
            vid_in_loss_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
